// File: rtl/keypad_pkg.sv
// Shared types and sizing for the keypad scan decoder.
// Purely declarative; no timing of its own.
// Classification helpers are combinational and carry no flow control.
package keypad_pkg;

  localparam int KEY_CODE_W = 4;
  localparam int NUM_ROWS   = 4;
  localparam int NUM_COLS   = 4;
  localparam int NUM_KEYS   = NUM_ROWS * NUM_COLS;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CLS_NONE   = 2'd0,
    CLS_SINGLE = 2'd1,
    CLS_MULTI  = 2'd2
  } class_t;

  // How many keys a frame snapshot holds: none, exactly one, or several.
  function automatic class_t classify(input logic [NUM_KEYS-1:0] snap);
    int n;
    n = 0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      n = n + int'(snap[i]);
    end
    if (n == 0) return CLS_NONE;
    else if (n == 1) return CLS_SINGLE;
    return CLS_MULTI;
  endfunction

  // Index of the lowest set bit; only meaningful for a SINGLE snapshot.
  function automatic logic [KEY_CODE_W-1:0] lowest_index(input logic [NUM_KEYS-1:0] snap);
    logic [KEY_CODE_W-1:0] idx;
    idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (snap[i]) idx = KEY_CODE_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scan_decoder_if.sv
// Key event channel: key code, valid/ready handshake and overrun pulse.
// Pure wiring, zero latency.
// Producer holds key_valid/key_code until key_ready is seen high.
interface keypad_scan_decoder_if;
  import keypad_pkg::*;

  logic [KEY_CODE_W-1:0] key_code;
  logic                  key_valid;
  logic                  key_ready;
  logic                  overrun;

  modport master (
    output key_code,
    output key_valid,
    output overrun,
    input  key_ready
  );

  modport slave (
    input  key_code,
    input  key_valid,
    input  overrun,
    output key_ready
  );

endinterface

// File: rtl/onehot_enc4.sv
// 4-bit one-hot column to 2-bit index, plus a strict one-hot flag.
// Combinational, zero latency.
// No flow control; the index falls back to the lowest set bit (0 for all-zero).
module onehot_enc4 (
  input  logic [3:0] i_onehot,
  output logic [1:0] o_idx,
  output logic       o_valid
);

  // Lowest-set-bit priority encode and exact one-hot detection.
  always_comb begin
    o_idx = 2'd0;
    if (i_onehot[0])      o_idx = 2'd0;
    else if (i_onehot[1]) o_idx = 2'd1;
    else if (i_onehot[2]) o_idx = 2'd2;
    else if (i_onehot[3]) o_idx = 2'd3;
    o_valid = $onehot(i_onehot);
  end

endmodule

// File: rtl/keypad_scan_decoder.sv
// Keypad scan decoder: frames row samples into 16-key snapshots, debounces, emits key codes.
// Event valid the cycle after the frame-ending col_step; rows see a 2-flop synchronizer.
// A new event while one is still pending (and not accepted that cycle) is dropped with an overrun pulse.
// Optional build macro KEYPAD_ONEHOT_CHECK_EN enables the sticky onehot_err check and frame discard.
module keypad_scan_decoder
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_COLS-1:0]   col_onehot,
  input  logic                  col_step,
  input  logic [NUM_ROWS-1:0]   row_n,
  output logic                  onehot_err,
  keypad_scan_decoder_if.master kif
);

  localparam logic [3:0] DS = 4'(DEBOUNCE_SCANS);

  logic [NUM_ROWS-1:0]   r_row_meta;
  logic [NUM_ROWS-1:0]   r_row_s;
  logic [1:0]            w_col_idx;
  logic                  w_col_valid;
  logic                  w_is_first;
  logic                  w_is_last;
  logic                  w_bad;
  logic                  w_record;
  logic                  w_eval;
  logic [NUM_KEYS-1:0]   r_snap;
  logic [NUM_KEYS-1:0]   w_snap_next;
  logic                  r_frame_active;
  class_t                w_cls;
  logic [KEY_CODE_W-1:0] w_code;
  state_t                r_state;
  state_t                w_state_nx;
  logic [3:0]            r_cnt;
  logic [3:0]            w_cnt_nx;
  logic [3:0]            w_cnt_inc;
  logic [KEY_CODE_W-1:0] r_cand;
  logic [KEY_CODE_W-1:0] w_cand_nx;
  logic                  w_emit;
  logic [KEY_CODE_W-1:0] w_emit_code;
  logic [KEY_CODE_W-1:0] r_key_code;
  logic                  r_key_valid;
  logic                  r_overrun;

  onehot_enc4 u_enc (
    .i_onehot (col_onehot),
    .o_idx    (w_col_idx),
    .o_valid  (w_col_valid)
  );

  // Two-flop synchronizer for the asynchronous rows; idle rows read high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_row_meta <= '1;
      r_row_s    <= '1;
    end else begin
      r_row_meta <= row_n;
      r_row_s    <= r_row_meta;
    end
  end

  // Frame bookkeeping: which steps are recorded, which one evaluates, and the merged snapshot.
  always_comb begin
    w_is_first = w_col_valid && (w_col_idx == 2'd0);
    w_is_last  = w_col_valid && (w_col_idx == 2'd3);
`ifdef KEYPAD_ONEHOT_CHECK_EN
    w_bad      = col_step && !w_col_valid;
`else
    w_bad      = 1'b0;
`endif
    w_record   = col_step && !w_bad && (r_frame_active || w_is_first);
    w_eval     = w_record && w_is_last;
    // A column-0 step opens a fresh frame, so stale bits never leak in.
    w_snap_next = w_is_first ? '0 : r_snap;
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (!r_row_s[r]) w_snap_next[r*NUM_COLS + int'(w_col_idx)] = 1'b1;
    end
    w_cls  = classify(w_snap_next);
    w_code = lowest_index(w_snap_next);
  end

  // Snapshot and alignment state; a bad column step drops the frame and waits for column 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_snap         <= '0;
      r_frame_active <= 1'b0;
    end else if (w_bad) begin
      r_snap         <= '0;
      r_frame_active <= 1'b0;
    end else if (w_record) begin
      r_frame_active <= 1'b1;
      r_snap         <= w_eval ? '0 : w_snap_next;
    end
  end

  // Debounce FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_cand  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_cand  <= w_cand_nx;
    end
  end

  // Debounce FSM next state: only moves on an evaluated frame; cnt counts identical frames.
  always_comb begin
    w_state_nx  = r_state;
    w_cnt_nx    = r_cnt;
    w_cand_nx   = r_cand;
    w_emit      = 1'b0;
    w_emit_code = r_cand;
    w_cnt_inc   = r_cnt + 4'd1;
    if (w_eval) begin
      case (r_state)
        ST_IDLE: begin
          if (w_cls == CLS_SINGLE) begin
            w_cand_nx = w_code;
            w_cnt_nx  = 4'd1;
            if (DS == 4'd1) begin
              w_emit      = 1'b1;
              w_emit_code = w_code;
              w_state_nx  = ST_HELD;
            end else begin
              w_state_nx  = ST_DEBOUNCE;
            end
          end
        end
        ST_DEBOUNCE: begin
          if ((w_cls == CLS_SINGLE) && (w_code == r_cand)) begin
            w_cnt_nx = w_cnt_inc;
            if (w_cnt_inc >= DS) begin
              w_emit     = 1'b1;
              w_state_nx = ST_HELD;
            end
          end else begin
            w_cnt_nx   = '0;
            w_state_nx = ST_IDLE;
          end
        end
        ST_HELD: begin
          if (w_cls == CLS_NONE) begin
            w_cnt_nx   = 4'd1;
            w_state_nx = (DS == 4'd1) ? ST_IDLE : ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (w_cls == CLS_NONE) begin
            w_cnt_nx = w_cnt_inc;
            if (w_cnt_inc >= DS) w_state_nx = ST_IDLE;
          end else begin
            w_state_nx = ST_HELD;
          end
        end
        default: w_state_nx = ST_IDLE;
      endcase
    end
  end

  // Event output register: load when the slot is free or being emptied this cycle, else flag overrun.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_key_code  <= '0;
      r_key_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (w_emit) begin
        if (!r_key_valid || kif.key_ready) begin
          r_key_code  <= w_emit_code;
          r_key_valid <= 1'b1;
        end else begin
          r_overrun   <= 1'b1;
        end
      end else if (r_key_valid && kif.key_ready) begin
        r_key_valid <= 1'b0;
      end
    end
  end

  assign kif.key_code  = r_key_code;
  assign kif.key_valid = r_key_valid;
  assign kif.overrun   = r_overrun;

`ifdef KEYPAD_ONEHOT_CHECK_EN
  logic r_onehot_err;

  // Sticky record of any column step whose column select was not one-hot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   r_onehot_err <= 1'b0;
    else if (w_bad) r_onehot_err <= 1'b1;
  end

  assign onehot_err = r_onehot_err;
`else
  assign onehot_err = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_scan_decoder.sv
module tb_keypad_scan_decoder;
  import keypad_pkg::*;

  localparam int DS = 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] col_onehot = 4'b0001;
  logic       col_step = 1'b0;
  logic [3:0] row_n = 4'hF;
  logic       onehot_err;

  keypad_scan_decoder_if kif ();

  keypad_scan_decoder #(.DEBOUNCE_SCANS(DS)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .col_onehot (col_onehot),
    .col_step   (col_step),
    .row_n      (row_n),
    .onehot_err (onehot_err),
    .kif        (kif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: frame-level debounce expressed as run lengths.
  bit         m_held;
  int         m_run;
  int         m_relrun;
  int         m_last;
  bit         m_pend;
  logic [3:0] m_code;
  bit         m_ovr;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] key(input int code);
    logic [15:0] k;
    k = '0;
    k[code] = 1'b1;
    return k;
  endfunction

  task automatic model_reset();
    m_held = 0; m_run = 0; m_relrun = 0; m_last = 0;
    m_pend = 0; m_code = 4'h0; m_ovr = 0;
  endtask

  task automatic model_frame(input logic [15:0] keys, input bit acc);
    int  n;
    int  c;
    bit  ev;
    n  = $countones(keys);
    c  = 0;
    ev = 0;
    m_ovr = 0;
    for (int i = 15; i >= 0; i--) if (keys[i]) c = i;
    if (acc) m_pend = 0;
    if (!m_held) begin
      if (n == 1 && (m_run == 0 || c == m_last)) begin
        m_run++;
        m_last = c;
        if (m_run == DS) begin ev = 1; m_held = 1; m_relrun = 0; end
      end else begin
        m_run = 0;
      end
    end else begin
      if (n == 0) begin
        m_relrun++;
        if (m_relrun == DS) begin m_held = 0; m_run = 0; end
      end else begin
        m_relrun = 0;
      end
    end
    if (ev) begin
      if (!m_pend) begin m_pend = 1; m_code = 4'(c); end
      else m_ovr = 1;
    end
  endtask

  task automatic check_outputs(input string tag);
    chk1({tag, ".valid"},   kif.key_valid, m_pend);
    chk4({tag, ".code"},    kif.key_code,  m_code);
    chk1({tag, ".overrun"}, kif.overrun,   m_ovr);
  endtask

  // One full aligned frame; acc raises key_ready on the evaluating step.
  task automatic drive_frame(input logic [15:0] keys, input bit acc, input string tag);
    for (int c = 0; c < 4; c++) begin
      row_n = ~{keys[12+c], keys[8+c], keys[4+c], keys[c]};
      repeat (4) @(negedge clk);
      col_onehot = 4'(1 << c);
      col_step = 1'b1;
      if (c == 3) kif.key_ready = acc;
      @(negedge clk);
      col_step = 1'b0;
      kif.key_ready = 1'b0;
    end
    model_frame(keys, acc);
    check_outputs(tag);
  endtask

  task automatic stray_step(input logic [3:0] col, input logic [3:0] rows);
    row_n = rows;
    repeat (4) @(negedge clk);
    col_onehot = col;
    col_step = 1'b1;
    @(negedge clk);
    col_step = 1'b0;
  endtask

  task automatic accept(input string tag);
    kif.key_ready = 1'b1;
    @(negedge clk);
    kif.key_ready = 1'b0;
    m_pend = 0;
    m_ovr = 0;
    chk1({tag, ".valid_fall"}, kif.key_valid, 1'b0);
  endtask

  task automatic apply_reset(input string tag);
    reset_n = 1'b0;
    @(negedge clk);
    model_reset();
    chk4({tag, ".code"},    kif.key_code,  4'h0);
    chk1({tag, ".valid"},   kif.key_valid, 1'b0);
    chk1({tag, ".overrun"}, kif.overrun,   1'b0);
    chk1({tag, ".err"},     onehot_err,    1'b0);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    kif.key_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    apply_reset("reset");

    // Unaligned steps after reset must not count as frames.
    repeat (3) begin
      stray_step(4'b0100, 4'b0111);
      stray_step(4'b1000, 4'b0111);
    end
    chk1("unaligned.valid", kif.key_valid, 1'b0);

    // Key 9 (row 2, column 1) for three frames gives exactly one event.
    for (int f = 0; f < 3; f++) drive_frame(key(9), 0, "press9");
    repeat (3) @(negedge clk);
    chk1("press9.hold_valid", kif.key_valid, 1'b1);
    chk4("press9.hold_code",  kif.key_code,  4'h9);
    accept("press9");
    for (int f = 0; f < 2; f++) drive_frame(key(9), 0, "held9");
    for (int f = 0; f < 3; f++) drive_frame('0, 0, "rel9");

    // Short press of two frames never emits.
    for (int f = 0; f < 2; f++) drive_frame(key(9), 0, "short9");
    for (int f = 0; f < 3; f++) drive_frame('0, 0, "short_rel");

    // Two keys on column 3 is MULTI; then key 3 alone emits.
    for (int f = 0; f < 3; f++) drive_frame(key(3) | key(7), 0, "multi");
    for (int f = 0; f < 3; f++) drive_frame(key(3), 0, "press3");
    accept("press3");
    for (int f = 0; f < 3; f++) drive_frame('0, 0, "rel3");

    // Unconsumed event 5, then key A: dropped with overrun, code stays 5.
    for (int f = 0; f < 3; f++) drive_frame(key(5), 0, "press5");
    for (int f = 0; f < 3; f++) drive_frame('0, 0, "rel5");
    for (int f = 0; f < 3; f++) drive_frame(key(10), 0, "ovrA");
    @(negedge clk);
    m_ovr = 0;
    chk1("ovrA.pulse_end", kif.overrun, 1'b0);
    chk4("ovrA.code_kept", kif.key_code, 4'h5);
    accept("ovr");
    for (int f = 0; f < 3; f++) drive_frame('0, 0, "relA");

    // Handshake coinciding with the evaluating step: old event leaves, new one loads.
    for (int f = 0; f < 3; f++) drive_frame(key(6), 0, "press6");
    for (int f = 0; f < 3; f++) drive_frame('0, 0, "rel6");
    for (int f = 0; f < 2; f++) drive_frame(key(2), 0, "press2");
    drive_frame(key(2), 1, "press2_acc");
    accept("press2");
    for (int f = 0; f < 3; f++) drive_frame('0, 0, "rel2");

`ifdef KEYPAD_ONEHOT_CHECK_EN
    // Bad column select discards the frame, keeps debounce progress, latches the flag.
    drive_frame(key(12), 0, "err_pre");
    stray_step(4'b0001, 4'b0111);
    stray_step(4'b0110, 4'b0111);
    chk1("onehot.err_set", onehot_err, 1'b1);
    stray_step(4'b0100, 4'b0111);
    stray_step(4'b1000, 4'b0111);
    chk1("onehot.discard_valid", kif.key_valid, 1'b0);
    chk1("onehot.err_sticky", onehot_err, 1'b1);
    for (int f = 0; f < 2; f++) drive_frame(key(12), 0, "err_post");
    apply_reset("err_reset");
`else
    chk1("onehot.tied_low", onehot_err, 1'b0);
`endif

    // Reset in the middle of a debounce restarts everything.
    for (int f = 0; f < 2; f++) drive_frame(key(9), 0, "mid9");
    apply_reset("mid_reset");
    drive_frame('0, 0, "mid_rel");
    for (int f = 0; f < 3; f++) drive_frame(key(9), 0, "after9");
    accept("after9");
    for (int f = 0; f < 3; f++) drive_frame('0, 0, "after_rel");

    // Random frames against the model.
    for (int f = 0; f < 60; f++) begin
      logic [15:0] k;
      int sel;
      int a;
      int b;
      sel = $urandom_range(0, 9);
      if (sel < 3) begin
        k = '0;
      end else if (sel < 8) begin
        k = key(($urandom_range(0, 1) == 1) ? 4 : 11);
      end else begin
        a = $urandom_range(0, 15);
        b = (a + 1 + $urandom_range(0, 14)) % 16;
        k = key(a) | key(b);
      end
      drive_frame(k, ($urandom_range(0, 3) == 0), "rand");
      if (m_pend && $urandom_range(0, 2) == 0) accept("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/keypad_scan_decoder.md
# keypad_scan_decoder

Downstream consumer of the 4-bit one-hot column ring counter. It samples four active-low keypad rows against the currently driven column and assembles a 16-key snapshot per 4-column scan frame. It debounces press and release over whole frames and delivers one key code per debounced press through a valid/ready handshake.

## Interface
Parameters:
- DEBOUNCE_SCANS, 3, consecutive identical frames needed to accept a press and, separately, a release; legal range 1..15.

Ports:
- clk  input  1  clock
- reset_n  input  1  asynchronous, active-low reset
- col_onehot  input  4  one-hot column currently driven by the ring counter
- col_step  input  1  single-cycle pulse; the ring counter advances at the end of this cycle
- row_n  input  4  raw active-low keypad rows, asynchronous to clk
- key_code  output  4  {row_idx[1:0], col_idx[1:0]}, i.e. row*4+col
- key_valid  output  1  key_code holds an undelivered event
- key_ready  input  1  consumer accepts the event when key_valid && key_ready
- overrun  output  1  one-cycle pulse when an event is dropped
- onehot_err  output  1  sticky flag: col_onehot was not one-hot at a col_step

## Operation
- row_n passes through a 2-flop synchronizer, giving row_s. A row counts as pressed when row_s[r] == 0.
- On each col_step, the block records the 4 pressed-row bits for col_idx = encode(col_onehot) into a 16-bit snapshot.
- Frame alignment: a frame starts at a col_step with col_onehot == 4'b0001. Steps taken before the first such step after reset are ignored. The frame ends, and is evaluated, at the col_step with col_onehot == 4'b1000. The snapshot clears after each evaluation.
- Evaluation classes: NONE (0 bits set), SINGLE (exactly 1 bit set, code = its index), MULTI (2 or more bits set).
- FSM states IDLE, DEBOUNCE, HELD, RELEASE. The frame counter cnt saturates at DEBOUNCE_SCANS.
  - IDLE: SINGLE → DEBOUNCE, cand=code, cnt=1. If DEBOUNCE_SCANS == 1, emit the event and go to HELD instead.
  - DEBOUNCE: SINGLE with code == cand → cnt++. When cnt reaches DEBOUNCE_SCANS, emit cand and go to HELD. Any other class or code → IDLE.
  - HELD: NONE → RELEASE, cnt=1 (for DEBOUNCE_SCANS == 1, go directly to IDLE). SINGLE or MULTI → stay in HELD.
  - RELEASE: NONE → cnt++; at DEBOUNCE_SCANS → IDLE. SINGLE or MULTI → HELD.
- Emit behaviour:
  - If key_valid is low, or key_valid && key_ready in the same cycle, key_code=cand and key_valid=1.
  - Otherwise the new event is dropped, overrun pulses, and the pending key_code is unchanged.
- key_valid and key_code stay stable until the handshake completes. key_valid falls the cycle after key_ready is sampled high.
- Reset mid-operation clears everything, and frame alignment restarts.

## Timing
- Reset values: key_code=0, key_valid=0, overrun=0, onehot_err=0. FSM=IDLE, snapshot=0, frame not started.
- row_n must be stable for at least 3 clk before a col_step to be sampled, because of the synchronizer.
- Event latency: key_valid rises on the clock edge that ends the evaluating col_step cycle, so it is high in the next cycle.
- Minimum press-to-event time is DEBOUNCE_SCANS frames.
- A col_step coinciding with a handshake is legal. Both take effect in the same cycle.

## Configuration
- Macro: KEYPAD_ONEHOT_CHECK_EN.
- Defined:
  - Any col_step with a col_onehot that is not one-hot sets onehot_err (sticky until reset).
  - That frame is discarded: snapshot cleared, alignment lost until the next 4'b0001 step.
  - FSM state and cnt are unchanged.
- Undefined:
  - onehot_err is tied to 0.
  - col_idx is the lowest set bit; 4'b0000 decodes as column 0.
  - No frame is discarded.

## Structure
- Package keypad_pkg:
  - FSM state enum.
  - KEY_CODE_W=4, NUM_ROWS=4, NUM_COLS=4.
  - Class enum (NONE/SINGLE/MULTI).
- Sub-module onehot_enc4: 4-bit one-hot to 2-bit index, with a valid output used by the check.
- The synchronizer is inline flops.

## Test plan
- DEBOUNCE_SCANS=3, row 2 held low during column 1 for 3 frames → key_code=4'h9, key_valid=1 one cycle after the 3rd frame-end step; exactly one event.
- Same press but released after 2 frames → no key_valid; FSM returns to IDLE.
- Rows 0 and 1 pressed on column 3 → MULTI, no event; then a single key 4'h3 for 3 frames → event 4'h3.
- key_ready held 0 after event 4'h5; release (3 NONE frames), then press 4'hA for 3 frames → overrun pulse, key_code stays 4'h5; key_ready=1 → key_valid falls next cycle.
- With KEYPAD_ONEHOT_CHECK_EN, col_onehot=4'b0110 at a col_step → onehot_err=1 and stays 1; the frame is discarded; reset clears it.
- reset_n asserted mid-DEBOUNCE (cnt=2) → all outputs 0; after release, a full 3-frame press is needed before the next event.
